// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, port indices, one-hot helper.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return (idx == PORT_DBG) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle of the data-memory arbiter: per-port req/we/addr/wdata in, gnt/ack/rdata out.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    gnt;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  gnt, ack, rdata
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output gnt, ack, rdata
  );
endinterface

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin selector; on a tie the port that was not served last wins.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic [1:0] exclude,
  output logic       valid,
  output logic       winner
);

  logic [1:0] cand;

  always_comb begin
    cand   = req & ~exclude;
    valid  = |cand;
    winner = (cand == 2'b11) ? ~rr_last : cand[PORT_DBG];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a 256x8 single-port data memory; optional DMEM_ARB_STATS_EN adds cnt0/cnt1.
// Latency: ack two cycles after acceptance; back-to-back alternating ports complete every 2 cycles.
// Backpressure: a requester holds req until its ack; the acked port is skipped in its own ack cycle.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [7:0]    cnt0,
  output logic [7:0]    cnt1
`endif
);

  state_t        state, state_nxt;
  logic          rr_last;
  logic          cur;
  logic          cur_we;
  logic          accept;
  logic          pick_vld;
  logic          pick_win;
  logic [1:0]    excl;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [1:0]    gnt_q;
  logic [1:0]    ack_q;

  rr_pick2 u_pick (
    .req     (bus.req),
    .rr_last (rr_last),
    .exclude (excl),
    .valid   (pick_vld),
    .winner  (pick_win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // mem_we is gated by rst_n so an ACCESS write cannot land on the reset edge.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    excl      = 2'b00;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_we    = cur_we & rst_n;
        state_nxt = RESP;
      end
      RESP: begin
        excl = onehot2(cur);
        if (pick_vld) begin
          accept    = 1'b1;
          state_nxt = ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= PORT_DBG;
      cur     <= PORT_CPU;
      cur_we  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      gnt_q   <= 2'b00;
      ack_q   <= 2'b00;
    end else begin
      ack_q <= (state == ACCESS) ? onehot2(cur) : 2'b00;
      if (accept) begin
        cur     <= pick_win;
        rr_last <= pick_win;
        cur_we  <= bus.we[pick_win];
        addr_q  <= (pick_win == PORT_DBG) ? bus.addr1 : bus.addr0;
        wdata_q <= (pick_win == PORT_DBG) ? bus.wdata1 : bus.wdata0;
        gnt_q   <= onehot2(pick_win);
      end else if (state == RESP) begin
        gnt_q <= 2'b00;
      end
      if (state == ACCESS && !cur_we) rdata_q <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt0 <= 8'h00;
      cnt1 <= 8'h00;
    end else begin
      if (ack_q[PORT_CPU] && cnt0 != 8'hFF) cnt0 <= cnt0 + 8'd1;
      if (ack_q[PORT_DBG] && cnt1 != 8'hFF) cnt1 <= cnt1 + 8'd1;
    end
  end
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign bus.gnt   = gnt_q;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level memory model.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [7:0]    cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  logic       t_we    [2];
  logic [7:0] t_addr  [2];
  logic [7:0] t_data  [2];

  always #20 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1)
`endif
  );

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  function automatic logic [1:0] oh(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.req = 2'b00; bus.we = 2'b00;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Presents a fresh random transaction for port p; addresses cluster so reads hit earlier writes.
  task automatic new_txn(input logic p);
    t_we[p]   = 1'($urandom_range(0, 1));
    t_addr[p] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
    t_data[p] = 8'($urandom);
    bus.we[p] = t_we[p];
    if (p) begin bus.addr1 = t_addr[p]; bus.wdata1 = t_data[p]; end
    else   begin bus.addr0 = t_addr[p]; bus.wdata0 = t_data[p]; end
  endtask

  task automatic test_reset;
    bus.req = 2'b11; bus.we = 2'b11;
    bus.addr0 = 8'h44; bus.addr1 = 8'h55; bus.wdata0 = 8'h99; bus.wdata1 = 8'h66;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.gnt); end
    checks++; if (bus.ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", bus.ack); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", bus.rdata); end
    checks++; if (mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 00 00", mem_addr, mem_wdata); end
`ifdef DMEM_ARB_STATS_EN
    checks++; if (cnt0 !== 8'h00 || cnt1 !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h %h want 00 00", cnt0, cnt1); end
`endif
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_wr_rd;
    bus.we[0] = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hA5; bus.req[0] = 1'b1;
    tick();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5) begin errors++; $display("FAIL single_access: got we %b addr %h data %h want 1 10 a5", mem_we, mem_addr, mem_wdata); end
    checks++; if (bus.gnt !== 2'b01 || bus.ack !== 2'b00) begin errors++; $display("FAIL single_gnt: got gnt %b ack %b want 01 00", bus.gnt, bus.ack); end
    tick();
    checks++; if (bus.ack !== 2'b01 || bus.gnt !== 2'b01 || mem_we !== 1'b0) begin errors++; $display("FAIL single_ack: got ack %b gnt %b we %b want 01 01 0", bus.ack, bus.gnt, mem_we); end
    ref_mem[8'h10] = 8'hA5;
    checks++; if (mem[8'h10] !== ref_mem[8'h10]) begin errors++; $display("FAIL single_mem: got %h want %h", mem[8'h10], ref_mem[8'h10]); end
    bus.req = 2'b00;
    tick();
    checks++; if (bus.gnt !== 2'b00 || bus.ack !== 2'b00 || mem_we !== 1'b0 || mem_addr !== 8'h10) begin errors++; $display("FAIL single_idle: got gnt %b ack %b we %b addr %h want 00 00 0 10", bus.gnt, bus.ack, mem_we, mem_addr); end
    bus.we[0] = 1'b0; bus.req[0] = 1'b1;
    tick();
    checks++; if (mem_we !== 1'b0 || bus.gnt !== 2'b01) begin errors++; $display("FAIL single_read_access: got we %b gnt %b want 0 01", mem_we, bus.gnt); end
    tick();
    checks++; if (bus.ack !== 2'b01 || bus.rdata !== 8'hA5) begin errors++; $display("FAIL single_read: got ack %b rdata %h want 01 a5", bus.ack, bus.rdata); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_simultaneous;
    apply_reset();
    bus.we = 2'b01; bus.addr0 = 8'h05; bus.wdata0 = 8'h22; bus.addr1 = 8'h05; bus.wdata1 = 8'hEE;
    bus.req = 2'b11;
    tick();
    checks++; if (bus.gnt !== 2'b01 || mem_we !== 1'b1 || mem_addr !== 8'h05) begin errors++; $display("FAIL simul_first: got gnt %b we %b addr %h want 01 1 05", bus.gnt, mem_we, mem_addr); end
    tick();
    checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL simul_ack0: got %b want 01", bus.ack); end
    bus.req[0] = 1'b0;
    ref_mem[8'h05] = 8'h22;
    tick();
    checks++; if (bus.gnt !== 2'b10 || mem_we !== 1'b0 || mem_addr !== 8'h05 || bus.ack !== 2'b00) begin errors++; $display("FAIL simul_second: got gnt %b we %b addr %h ack %b want 10 0 05 00", bus.gnt, mem_we, mem_addr, bus.ack); end
    tick();
    checks++; if (bus.ack !== 2'b10 || bus.rdata !== 8'h22) begin errors++; $display("FAIL simul_ack1: got ack %b rdata %h want 10 22", bus.ack, bus.rdata); end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back;
    int n = 0, cyc = 0, last_cyc = -1;
    logic exp_p = 1'b0;
    logic p;
    apply_reset();
    new_txn(1'b0); new_txn(1'b1);
    bus.req = 2'b11;
    while (n < 8 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.ack != 2'b00) begin
        p = bus.ack[1];
        checks++; if (bus.ack !== oh(exp_p)) begin errors++; $display("FAIL b2b_order: got ack %b want %b at access %0d", bus.ack, oh(exp_p), n); end
        if (last_cyc >= 0) begin
          checks++; if (cyc - last_cyc != 2) begin errors++; $display("FAIL b2b_spacing: got %0d cycles want 2", cyc - last_cyc); end
        end
        if (t_we[p]) ref_mem[t_addr[p]] = t_data[p];
        else begin
          checks++; if (bus.rdata !== ref_mem[t_addr[p]]) begin errors++; $display("FAIL b2b_rdata: got %h want %h addr %h", bus.rdata, ref_mem[t_addr[p]], t_addr[p]); end
        end
        new_txn(p);
        exp_p = ~exp_p;
        last_cyc = cyc;
        n++;
      end
    end
    checks++; if (n != 8) begin errors++; $display("FAIL b2b_timeout: got %0d accesses want 8", n); end
    bus.req = 2'b00;
    repeat (2) tick();
  endtask

  task automatic test_withdrawn;
    bus.we = 2'b01; bus.addr0 = 8'h40; bus.wdata0 = 8'h5A; bus.req = 2'b01;
    tick();
    bus.req[1] = 1'b1; bus.we[1] = 1'b1; bus.addr1 = 8'h41; bus.wdata1 = 8'hEE;
    tick();
    checks++; if (bus.ack !== 2'b01) begin errors++; $display("FAIL withdraw_ack0: got %b want 01", bus.ack); end
    ref_mem[8'h40] = 8'h5A;
    bus.req = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.gnt !== 2'b00 || bus.ack !== 2'b00 || mem_we !== 1'b0) begin errors++; $display("FAIL withdraw_quiet: got gnt %b ack %b we %b want 00 00 0", bus.gnt, bus.ack, mem_we); end
    end
    checks++; if (mem[8'h41] !== ref_mem[8'h41]) begin errors++; $display("FAIL withdraw_mem: got %h want %h", mem[8'h41], ref_mem[8'h41]); end
  endtask

  task automatic test_reset_mid;
    bus.we = 2'b01; bus.addr0 = 8'h30; bus.wdata0 = 8'h77; bus.req = 2'b01;
    tick();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rstmid_access: got we %b want 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we_gate: got %b want 0", mem_we); end
    tick();
    checks++; if (mem[8'h30] !== ref_mem[8'h30]) begin errors++; $display("FAIL rstmid_mem: got %h want %h", mem[8'h30], ref_mem[8'h30]); end
    checks++; if (bus.ack !== 2'b00 || bus.gnt !== 2'b00) begin errors++; $display("FAIL rstmid_hs: got ack %b gnt %b want 00 00", bus.ack, bus.gnt); end
    idle_inputs();
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++; if (bus.ack !== 2'b00 || bus.gnt !== 2'b00) begin errors++; $display("FAIL rstmid_after: got ack %b gnt %b want 00 00", bus.ack, bus.gnt); end
`ifdef DMEM_ARB_STATS_EN
    checks++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL rstmid_cnt0: got %h want 00", cnt0); end
`endif
  endtask

  task automatic test_random;
    logic active [2];
    int   raised [2];
    int   done = 0;
    int   bad = 0;
    active[0] = 1'b0; active[1] = 1'b0;
    raised[0] = 0;    raised[1] = 0;
    idle_inputs();
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (bus.ack == 2'b11) begin
        checks++; errors++; $display("FAIL rand_ack_both: got %b want one-hot", bus.ack);
      end else if (bus.ack != 2'b00) begin
        for (int p = 0; p < 2; p++) if (bus.ack[p]) begin
          checks++; if (!active[p] || bus.gnt !== oh(1'(p))) begin errors++; $display("FAIL rand_ack_port: port %0d ack with active %b gnt %b", p, active[p], bus.gnt); end
          if (t_we[p]) ref_mem[t_addr[p]] = t_data[p];
          else begin
            checks++; if (bus.rdata !== ref_mem[t_addr[p]]) begin errors++; $display("FAIL rand_rdata: port %0d got %h want %h addr %h", p, bus.rdata, ref_mem[t_addr[p]], t_addr[p]); end
          end
          active[p] = 1'b0; bus.req[p] = 1'b0; done++;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (active[p] && cyc - raised[p] > 6) begin
          checks++; errors++; $display("FAIL rand_latency: port %0d waited %0d cycles want <= 6", p, cyc - raised[p]);
          active[p] = 1'b0; bus.req[p] = 1'b0;
        end
        if (!active[p] && $urandom_range(0, 1) == 1) begin
          new_txn(1'(p)); active[p] = 1'b1; raised[p] = cyc; bus.req[p] = 1'b1;
        end
      end
    end
    bus.req = 2'b00;
    repeat (6) tick();
    checks++; if (done < 50) begin errors++; $display("FAIL rand_throughput: got %0d accesses want >= 50", done); end
    for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_mem_image: got %0d differing bytes want 0", bad); end
  endtask

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'h00;
      ref_mem[a] = 8'h00;
    end
    idle_inputs();
    rst_n = 1'b1;
    test_reset();
    test_single_wr_rd();
    test_simultaneous();
    test_back_to_back();
    test_withdrawn();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
